// File: rtl/mux_display_pkg.sv
// Types, constants and helpers shared by the display multiplexer files.
package mux_display_pkg;
  `include "mux_display_defs.vh"

  localparam int            NUM_DIG      = 3;
  localparam int            IDX_W        = `MD_IDX_W;
  localparam logic [2:0]    AN_OFF       = `MD_AN_OFF;
  localparam logic [6:0]    SEG_OFF_AL   = `MD_SEG_OFF_AL;
  localparam logic [6:0]    SEG_OFF_AH   = `MD_SEG_OFF_AH;
  localparam logic [6:0]    SEG_ZERO_DEF = `MD_SEG_ZERO;

  typedef enum logic {ST_BLANK, ST_ON} slot_st_t;

  function automatic logic [6:0] seg_off(input logic act_low);
    return act_low ? SEG_OFF_AL : SEG_OFF_AH;
  endfunction

  // Active-low anode pattern selecting a single digit; anything else is all-off.
  function automatic logic [2:0] an_sel(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    return 3'b110;
      2'd1:    return 3'b101;
      2'd2:    return 3'b011;
      default: return AN_OFF;
    endcase
  endfunction
endpackage

// File: rtl/mux_display_7seg_divisor_tick.sv
// Modulo-DIV free-running counter with a slot_end flag held while count == DIV-1.
module divisor_tick #(
  parameter  int DIV = 1000,
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
)(
  input  logic          ck,
  input  logic          rst_n,
  output logic [CW-1:0] count,
  output logic          slot_end
);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  assign slot_end = (count == LAST);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)        count <= '0;
    else if (slot_end) count <= '0;
    else               count <= count + 1'b1;
  end
endmodule

// File: rtl/mux_display_defs.vh
// Shared constants for the multiplexed 7-segment display: segment-off codes for
// both polarities, the default "0" code, anode-off pattern and digit-index width.
`ifndef MUX_DISPLAY_DEFS_VH
`define MUX_DISPLAY_DEFS_VH
`define MD_SEG_OFF_AL 7'h7F
`define MD_SEG_OFF_AH 7'h00
`define MD_SEG_ZERO   7'h3F
`define MD_AN_OFF     3'b111
`define MD_IDX_W      2
`endif

// File: rtl/mux_display_7seg.sv
// Three-digit 7-segment scanner with per-frame shadow capture and a blanking gap
// per slot. Define MUX_DISPLAY_LZB_EN to blank leading zeros on digits 2 and 1.
module mux_display_7seg
  import mux_display_pkg::*;
#(
  parameter int         DIV         = 1000,
  parameter int         BLANK_CYC   = 50,
  parameter bit         SEG_ACT_LOW = 1'b1,
  parameter logic [6:0] SEG_ZERO    = SEG_ZERO_DEF
)(
  input  logic       ck,
  input  logic       rst_n,
  input  logic [6:0] sgm0,
  input  logic [6:0] sgm1,
  input  logic [6:0] sgm2,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);
  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYC);
  localparam logic [6:0]    SEG_OFF = seg_off(SEG_ACT_LOW);

  logic [CW-1:0]                cnt;
  logic                         slot_end;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         latch;
  logic [NUM_DIG-1:0][6:0]      sgm_v, sh_q;
  logic [NUM_DIG-1:0]           show;
  logic [6:0]                   sh_sel;
  logic                         show_sel;
  slot_st_t                     st_q, st_d;
  logic [2:0]                   an_q, an_d;
  logic [6:0]                   seg_q, seg_d;
  logic                         fs_q;

  divisor_tick #(.DIV(DIV)) u_tick (
    .ck       (ck),
    .rst_n    (rst_n),
    .count    (cnt),
    .slot_end (slot_end)
  );

  // Index 3 is illegal; recover to digit 0 rather than stalling there.
  always_comb begin
    idx_d = idx_q;
    if (idx_q > 2'd2)  idx_d = '0;
    else if (slot_end) idx_d = (idx_q == 2'd2) ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  assign latch = slot_end && (idx_q == 2'd2);
  assign sgm_v = {sgm2, sgm1, sgm0};

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_sh
    always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n)     sh_q[g] <= '0;
      else if (latch) sh_q[g] <= sgm_v[g];
    end
  end

`ifdef MUX_DISPLAY_LZB_EN
  // Blanking decision comes from the shadows, so it holds for the whole frame.
  assign show[0] = 1'b1;
  assign show[1] = !((sh_q[2] == SEG_ZERO) && (sh_q[1] == SEG_ZERO));
  assign show[2] = !(sh_q[2] == SEG_ZERO);
`else
  assign show = '1;
`endif

  always_comb begin
    sh_sel   = '0;
    show_sel = 1'b0;
    case (idx_q)
      2'd0:    begin sh_sel = sh_q[0]; show_sel = show[0]; end
      2'd1:    begin sh_sel = sh_q[1]; show_sel = show[1]; end
      2'd2:    begin sh_sel = sh_q[2]; show_sel = show[2]; end
      default: ;
    endcase
  end

  always_comb begin
    st_d  = ST_BLANK;
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    case (st_q)
      ST_BLANK: if (cnt >= BLANK_C && show_sel) st_d = ST_ON;
      ST_ON:    st_d = (cnt >= BLANK_C && show_sel) ? ST_ON : ST_BLANK;
      default:  st_d = ST_BLANK;
    endcase
    if (st_d == ST_ON) begin
      an_d  = an_sel(idx_q);
      seg_d = SEG_ACT_LOW ? ~sh_sel : sh_sel;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_BLANK;
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      fs_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      fs_q  <= latch;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_mux_display_7seg.sv
// Randomised/directed bench for mux_display_7seg (DIV=4, BLANK_CYC=1, active-low seg).
module tb_mux_display_7seg;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 3 * DIV;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] sgm0 = '0, sgm1 = '0, sgm2 = '0;
  logic [2:0] an;
  logic [6:0] seg;
  logic       frame_start;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;
  int first_fs = -1;
  logic [6:0] m_sh [3];

  mux_display_7seg #(.DIV(DIV), .BLANK_CYC(BLANK), .SEG_ACT_LOW(1'b1), .SEG_ZERO(7'h3F)) dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .sgm0        (sgm0),
    .sgm1        (sgm1),
    .sgm2        (sgm2),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic bit shown(input int d);
    bit r = 1'b1;
`ifdef MUX_DISPLAY_LZB_EN
    if (d == 2) r = (m_sh[2] != 7'h3F);
    if (d == 1) r = !((m_sh[2] == 7'h3F) && (m_sh[1] == 7'h3F));
`endif
    return r;
  endfunction

  // One clock of normal scanning: the model predicts what the registered outputs
  // show after this edge from the cycle position and the pre-edge shadow values.
  task automatic tick();
    int c, d, lows;
    logic [2:0] e_an;
    logic [6:0] e_seg;
    logic       e_fs;
    @(posedge ck);
    c = n % DIV;
    d = (n / DIV) % 3;
    e_an  = 3'b111;
    e_seg = 7'h7F;
    if (c >= BLANK && shown(d)) begin
      e_an[d] = 1'b0;
      e_seg   = ~m_sh[d];
    end
    e_fs = ((n % FRAME) == FRAME - 1);
    if (e_fs) begin
      m_sh[0] = sgm0; m_sh[1] = sgm1; m_sh[2] = sgm2;
    end
    n++;
    @(negedge ck);
    if (frame_start && first_fs < 0) first_fs = n;
    check("an", {29'd0, an}, {29'd0, e_an});
    check("seg", {25'd0, seg}, {25'd0, e_seg});
    check("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
    lows = 0;
    for (int i = 0; i < 3; i++) if (an[i] == 1'b0) lows++;
    check("an_onehot", lows > 1, 0);
  endtask

  task automatic reset_tick();
    @(posedge ck);
    sgm0 = 7'($urandom); sgm1 = 7'($urandom); sgm2 = 7'($urandom);
    @(negedge ck);
    check("rst_an", {29'd0, an}, 32'h7);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_fs", {31'd0, frame_start}, 0);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    n = 0;
    first_fs = -1;
    for (int i = 0; i < 3; i++) m_sh[i] = '0;
  endtask

  initial begin
    int found;
    for (int i = 0; i < 3; i++) m_sh[i] = '0;

    // Reset held for 5 cycles with random inputs.
    for (int i = 0; i < 5; i++) reset_tick();
    sgm0 = 7'h06; sgm1 = 7'h5B; sgm2 = 7'h4F;
    release_reset();

    // Two frames steady: first blank, second shows 79/24/30.
    for (int i = 0; i < 2 * FRAME; i++) tick();
    check("first_fs_latency", first_fs, 12);

    // Third frame: sgm1 changes mid digit-0 slot; visible only in the frame after.
    for (int i = 0; i < 2; i++) tick();
    sgm1 = 7'h66;
    for (int i = 0; i < FRAME - 2 + FRAME; i++) tick();

    // Leading-zero pattern, then tens digit becomes non-zero.
    sgm0 = 7'h06; sgm1 = 7'h3F; sgm2 = 7'h3F;
    for (int i = 0; i < 2 * FRAME; i++) tick();
    sgm1 = 7'h5B;
    for (int i = 0; i < 2 * FRAME; i++) tick();

    // Async reset while digit 1 is ON.
    found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      tick();
      if (an == 3'b101) found = 1;
    end
    check("wait_digit1_on", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", {29'd0, an}, 32'h7);
    check("async_seg", {25'd0, seg}, 32'h7F);
    check("async_fs", {31'd0, frame_start}, 0);
    @(negedge ck);
    for (int i = 0; i < 2; i++) reset_tick();
    sgm0 = 7'h06; sgm1 = 7'h5B; sgm2 = 7'h4F;
    release_reset();
    for (int i = 0; i < 2 * FRAME; i++) tick();
    check("restart_fs_latency", first_fs, 12);

    // Random codes with random mid-frame changes.
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 2))
            0:       sgm0 = 7'($urandom);
            1:       sgm1 = ($urandom_range(0, 1) != 0) ? 7'h3F : 7'($urandom);
            default: sgm2 = ($urandom_range(0, 1) != 0) ? 7'h3F : 7'($urandom);
          endcase
        end
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
